// File: rtl/terminal_pkg.sv
// rtl/terminal_pkg.sv - shared types and helpers for the UART terminal controller
package terminal_pkg;

  localparam int SLOT_W = 6;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_ECHO   = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_ECHO
  } term_state_e;

  // First display slot of history byte k (0 = newest); bytes fill from the top slot down.
  function automatic int hist_first_slot(input int k, input int digits, input int nib);
    return digits - (k + 1) * nib;
  endfunction

endpackage

// File: rtl/uart_terminal_ctrl_if.sv
// rtl/uart_terminal_ctrl_if.sv - rx/tx FIFO handshake between terminal controller and uart driver
interface uart_terminal_ctrl_if #(
  parameter int DBIT = 8
);
  logic [DBIT-1:0] r_data;
  logic            rx_empty;
  logic            rd_uart;
  logic [DBIT-1:0] w_data;
  logic            wr_uart;
  logic            tx_full;

  modport master (
    input  r_data, rx_empty, tx_full,
    output rd_uart, w_data, wr_uart
  );

  modport slave (
    output r_data, rx_empty, tx_full,
    input  rd_uart, w_data, wr_uart
  );
endinterface

// File: rtl/uart_terminal_ctrl_byte_history.sv
// rtl/uart_terminal_ctrl_byte_history.sv - HIST-deep received byte shift register with valid bits
module byte_history #(
  parameter int DBIT = 8,
  parameter int HIST = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift,
  input  logic [DBIT-1:0]      din,
  output logic [HIST*DBIT-1:0] data,
  output logic [HIST-1:0]      valid
);

  logic [HIST*DBIT-1:0]     data_q, data_d;
  logic [HIST-1:0]          valid_q, valid_d;
  logic [(HIST+1)*DBIT-1:0] data_ext;
  logic [HIST:0]            valid_ext;

  // Newest byte enters at entry 0; the oldest entry falls off the top.
  assign data_ext  = {data_q, din};
  assign valid_ext = {valid_q, 1'b1};

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (shift) begin
      data_d  = data_ext[HIST*DBIT-1:0];
      valid_d = valid_ext[HIST-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/uart_terminal_ctrl.sv
// rtl/uart_terminal_ctrl.sv - terminal controller: rx pop/history, echo, switch transmit, display packing
module uart_terminal_ctrl
  import terminal_pkg::*;
#(
  parameter int DBIT   = 8,
  parameter int HIST   = 2,
  parameter int DIGITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               mode,
  input  logic                     rd_btn,
  input  logic                     wr_btn,
  input  logic [DBIT-1:0]          sw_data,
  uart_terminal_ctrl_if.master     uart,
  output logic [SLOT_W*DIGITS-1:0] digits,
  output logic [7:0]               rx_count,
  output logic                     tx_drop
);

  localparam int NIB = DBIT / 4;

  term_state_e     state_q, state_d;
  logic [DBIT-1:0] echo_q, echo_d;
  logic            pend_valid_q, pend_valid_d;
  logic [DBIT-1:0] pend_data_q, pend_data_d;
  logic [7:0]      rx_count_q, rx_count_d;
  logic            tx_drop_q, tx_drop_d;

  logic            pop, echo_pop;
  logic            wr_w;
  logic [DBIT-1:0] wdata_w;
  logic            is_manual, is_echo;

  logic [HIST*DBIT-1:0] hist_data;
  logic [HIST-1:0]      hist_valid;

  assign is_manual = (mode == MODE_MANUAL);
  assign is_echo   = (mode == MODE_ECHO);

  byte_history #(
    .DBIT (DBIT),
    .HIST (HIST)
  ) u_hist (
    .clk   (clk),
    .reset (reset),
    .shift (pop),
    .din   (uart.r_data),
    .data  (hist_data),
    .valid (hist_valid)
  );

  always_comb begin
    state_d      = state_q;
    echo_d       = echo_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    rx_count_d   = rx_count_q;
    tx_drop_d    = tx_drop_q;
    pop          = 1'b0;
    echo_pop     = 1'b0;
    wr_w         = 1'b0;
    wdata_w      = '0;
    if (!reset) begin
      pop      = !uart.rx_empty && (is_manual ? rd_btn : (state_q == ST_IDLE));
      echo_pop = pop && is_echo && (state_q == ST_IDLE);
      if (pop) begin
        rx_count_d = rx_count_q + 8'd1;
      end
      if (echo_pop) begin
        state_d = ST_ECHO;
        echo_d  = uart.r_data;
      end
      // Single transmit port: echo first, then the pending byte, then an immediate switch send.
      if (state_q == ST_ECHO) begin
        if (!uart.tx_full) begin
          wr_w    = 1'b1;
          wdata_w = echo_q;
          state_d = ST_IDLE;
        end
      end else if (pend_valid_q && !uart.tx_full) begin
        wr_w         = 1'b1;
        wdata_w      = pend_data_q;
        pend_valid_d = 1'b0;
      end else if (wr_btn && !pend_valid_q && !echo_pop && !uart.tx_full) begin
        wr_w    = 1'b1;
        wdata_w = sw_data;
      end
      if (wr_btn) begin
        if (pend_valid_q) begin
          tx_drop_d = 1'b1;
        end else if (state_q == ST_ECHO || echo_pop) begin
          pend_valid_d = 1'b1;
          pend_data_d  = sw_data;
        end else if (uart.tx_full) begin
          tx_drop_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      echo_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      rx_count_q   <= '0;
      tx_drop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      echo_q       <= echo_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      rx_count_q   <= rx_count_d;
      tx_drop_q    <= tx_drop_d;
    end
  end

  assign uart.rd_uart = pop;
  assign uart.wr_uart = wr_w;
  assign uart.w_data  = wdata_w;

  // During reset only the switch nibbles are shown.
  always_comb begin
    digits = '0;
    for (int n = 0; n < NIB; n++) begin
      digits[n*SLOT_W +: SLOT_W] = {1'b1, sw_data[4*n +: 4], 1'b0};
    end
    if (!reset) begin
      for (int k = 0; k < HIST; k++) begin
        for (int n = 0; n < NIB; n++) begin
          digits[(hist_first_slot(k, DIGITS, NIB) + n)*SLOT_W +: SLOT_W] =
            {hist_valid[k], hist_data[k*DBIT + 4*n +: 4], 1'b0};
        end
      end
      digits[0] = tx_drop_q;
    end
  end

  assign rx_count = rx_count_q;
  assign tx_drop  = tx_drop_q;

endmodule

// File: tb/tb_uart_terminal_ctrl.sv
// tb/tb_uart_terminal_ctrl.sv - directed and randomized bench for uart_terminal_ctrl
module tb_uart_terminal_ctrl;

  localparam int DBIT   = 8;
  localparam int HIST   = 2;
  localparam int DIGITS = 8;
  localparam int NIB    = DBIT / 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        rd_btn, wr_btn;
  logic [7:0]  sw_data;
  logic [47:0] digits;
  logic [7:0]  rx_count;
  logic        tx_drop;

  always #5 clk = ~clk;

  uart_terminal_ctrl_if #(.DBIT(DBIT)) u_if ();

  uart_terminal_ctrl #(
    .DBIT   (DBIT),
    .HIST   (HIST),
    .DIGITS (DIGITS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .rd_btn   (rd_btn),
    .wr_btn   (wr_btn),
    .sw_data  (sw_data),
    .uart     (u_if),
    .digits   (digits),
    .rx_count (rx_count),
    .tx_drop  (tx_drop)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: transmit work as queues, history as a newest-first byte list.
  bit         m_echo;
  logic [7:0] m_echo_b;
  logic [7:0] m_pend[$];
  logic [7:0] m_hist[$];
  int         m_cnt;
  bit         m_drop;

  function automatic logic [47:0] exp_digits();
    logic [47:0] d;
    logic [7:0]  b;
    int          base;
    d = '0;
    for (int n = 0; n < NIB; n++) d[n*6 +: 6] = {1'b1, sw_data[4*n +: 4], 1'b0};
    if (!reset) begin
      for (int k = 0; k < m_hist.size(); k++) begin
        b    = m_hist[k];
        base = DIGITS - (k + 1) * NIB;
        for (int n = 0; n < NIB; n++) d[(base+n)*6 +: 6] = {1'b1, b[4*n +: 4], 1'b0};
      end
      d[0] = m_drop;
    end
    return d;
  endfunction

  task automatic step();
    bit         pop_e, echo_pop, wr_e, leave, pend_sent, had_pend;
    logic [7:0] wd_e;
    #1;
    pop_e = 0; echo_pop = 0; wr_e = 0; wd_e = 8'h00; leave = 0; pend_sent = 0;
    had_pend = (m_pend.size() != 0);
    if (!reset) begin
      pop_e    = !u_if.rx_empty && ((mode == 2'b00) ? rd_btn : !m_echo);
      echo_pop = pop_e && (mode == 2'b10) && !m_echo;
      if (m_echo) begin
        if (!u_if.tx_full) begin wr_e = 1; wd_e = m_echo_b; leave = 1; end
      end else if (had_pend && !u_if.tx_full) begin
        wr_e = 1; wd_e = m_pend[0]; pend_sent = 1;
      end else if (wr_btn && !had_pend && !echo_pop && !u_if.tx_full) begin
        wr_e = 1; wd_e = sw_data;
      end
    end
    check_eq("rd_uart", u_if.rd_uart, pop_e);
    check_eq("wr_uart", u_if.wr_uart, wr_e);
    if (wr_e || reset) check_eq("w_data", u_if.w_data, wd_e);
    check_eq("digits", digits, exp_digits());
    check_eq("rx_count", rx_count, m_cnt);
    check_eq("tx_drop", tx_drop, m_drop);
    @(posedge clk);
    if (reset) begin
      m_echo = 0; m_echo_b = 0; m_pend.delete(); m_hist.delete(); m_cnt = 0; m_drop = 0;
    end else begin
      if (pend_sent) void'(m_pend.pop_front());
      if (wr_btn) begin
        if (had_pend) m_drop = 1;
        else if (m_echo || echo_pop) m_pend.push_back(sw_data);
        else if (u_if.tx_full) m_drop = 1;
      end
      if (leave) m_echo = 0;
      if (pop_e) begin
        m_hist.push_front(u_if.r_data);
        if (m_hist.size() > HIST) void'(m_hist.pop_back());
        m_cnt = (m_cnt + 1) % 256;
      end
      if (echo_pop) begin m_echo = 1; m_echo_b = u_if.r_data; end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1; rd_btn = 0; wr_btn = 0;
    step();
    reset = 0;
  endtask

  initial begin
    reset = 1; mode = 2'b00; rd_btn = 0; wr_btn = 0; sw_data = 8'hA5;
    u_if.rx_empty = 1; u_if.r_data = 8'h00; u_if.tx_full = 0;
    m_echo = 0; m_echo_b = 0; m_cnt = 0; m_drop = 0;
    step(); step();
    reset = 0;
    step();
    check_eq("rst_sw_slots", digits[11:0], 12'hD2A);
    check_eq("rst_hist_slots", digits[47:12], 36'h0);
    check_eq("rst_rx_count", rx_count, 8'd0);

    // Manual read
    u_if.r_data = 8'h3C; u_if.rx_empty = 0;
    step();
    rd_btn = 1; step();
    rd_btn = 0; u_if.rx_empty = 1; step();
    check_eq("man_slots67", digits[47:36], 12'h9B8);
    check_eq("man_rx_count", rx_count, 8'd1);
    rd_btn = 1; step();
    rd_btn = 0; step();

    // Auto history
    do_reset();
    mode = 2'b01; u_if.rx_empty = 0; u_if.r_data = 8'h11; step();
    u_if.r_data = 8'h22; step();
    u_if.rx_empty = 1; step();
    check_eq("auto_slots67", digits[47:36], 12'h924);
    check_eq("auto_slots45", digits[35:24], 12'h8A2);
    check_eq("auto_rx_count", rx_count, 8'd2);

    // Echo with backpressure; later FIFO bytes must not pop during the stall
    mode = 2'b10; u_if.tx_full = 1; u_if.rx_empty = 0; u_if.r_data = 8'h7E; step();
    u_if.r_data = 8'h99;
    repeat (5) step();
    check_eq("stall_rx_count", rx_count, 8'd3);
    u_if.tx_full = 0; #1;
    check_eq("echo_wr", u_if.wr_uart, 1'b1);
    check_eq("echo_data", u_if.w_data, 8'h7E);
    step();
    u_if.rx_empty = 1; step();

    // Collision: echo goes first, switch byte next cycle
    u_if.rx_empty = 0; u_if.r_data = 8'h41; wr_btn = 1; sw_data = 8'h55; step();
    u_if.rx_empty = 1; wr_btn = 0; #1;
    check_eq("coll_echo", u_if.w_data, 8'h41);
    step(); #1;
    check_eq("coll_sw", u_if.w_data, 8'h55);
    check_eq("coll_wr", u_if.wr_uart, 1'b1);
    step();
    check_eq("coll_nodrop", tx_drop, 1'b0);

    // Third request while the pending slot is held full
    u_if.tx_full = 1; u_if.rx_empty = 0; u_if.r_data = 8'h41; wr_btn = 1; step();
    u_if.rx_empty = 1; step();
    wr_btn = 0; step();
    check_eq("drop_set", tx_drop, 1'b1);
    check_eq("drop_dp", digits[0], 1'b1);
    u_if.tx_full = 0; repeat (3) step();

    // Reset mid-echo abandons the echo
    u_if.tx_full = 1; u_if.rx_empty = 0; u_if.r_data = 8'h12; step();
    u_if.rx_empty = 1; reset = 1; u_if.tx_full = 0; #1;
    check_eq("rst_echo_wr", u_if.wr_uart, 1'b0);
    step();
    reset = 0; repeat (2) step();

    // Counter wrap with a sticky drop already set
    mode = 2'b00; u_if.tx_full = 1; wr_btn = 1; step();
    wr_btn = 0; u_if.tx_full = 0; mode = 2'b01; u_if.rx_empty = 0;
    for (int i = 0; i < 256; i++) begin
      u_if.r_data = 8'($urandom);
      step();
    end
    u_if.rx_empty = 1; step();
    check_eq("wrap_count", rx_count, 8'd0);
    check_eq("wrap_drop", tx_drop, 1'b1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
      reset         = ($urandom_range(0, 199) == 0);
      u_if.rx_empty = ($urandom_range(0, 2) == 0);
      u_if.r_data   = 8'($urandom);
      u_if.tx_full  = ($urandom_range(0, 3) == 0);
      rd_btn        = ($urandom_range(0, 3) == 0);
      wr_btn        = ($urandom_range(0, 4) == 0);
      sw_data       = 8'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
